mod_updown_counter: RTL and testbench

Parametrised modulo-N counter. Supports up, down and bounce (triangle) modes, with synchronous load, clear and count enable. It flags terminal-count events and overflow, and can be built to wrap or to saturate. It is the general counting primitive for timers, address generators and LED sequencers, and replaces fixed 4-bit mod-16 up/down counters.

---
 rtl/mod_updown_counter.sv | 166 ++++++++++++++++
 tb/tb_mod_updown_counter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_updown_counter.sv
// -----------------------------------------------------------------------------
// mod_updown_counter
//
// General-purpose modulo-N counter. It counts in one of three modes:
//   - up: 0 .. MODULUS-1
//   - down: MODULUS-1 .. 0
//   - bounce: a triangle sweep 0 .. MODULUS-1 .. 0 ..
// It also has a hold mode, synchronous clear and parallel load, and a count
// enable. Terminal-count events produce a one-cycle pulse on o_tc. Up/down
// over/underflow sets a sticky o_ovf. At the limits the counter either wraps
// or saturates, depending on SATURATE.
//
// Parameters
//   WIDTH    : counter width in bits (1..16)
//   MODULUS  : count range 0..MODULUS-1 (2..2**WIDTH)
//   SATURATE : 0 = wrap at the limits, 1 = hold at the limits (up/down only)
//
// Ports
//   i_clk   in   clock, rising edge
//   i_rst   in   asynchronous active-high reset
//   i_en    in   count enable, one step per enabled cycle
//   i_clr   in   synchronous clear (highest priority)
//   i_load  in   synchronous load of i_data (clamped to MODULUS-1)
//   i_data  in   load value
//   i_mode  in   00 up, 01 down, 10 bounce, 11 hold
//   o_cnt   out  registered count
//   o_dir   out  direction of the last/next step (0 up, 1 down)
//   o_tc    out  registered terminal-count pulse
//   o_ovf   out  sticky overflow/underflow flag
// -----------------------------------------------------------------------------
module mod_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic [1:0]       i_mode,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_dir,
    output logic             o_tc,
    output logic             o_ovf
);

    // Reject illegal parameter combinations at elaboration time.
    generate
        if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
            $error("mod_updown_counter: WIDTH must be in 1..16");
        end
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
            $error("mod_updown_counter: MODULUS must be in 2..2**WIDTH");
        end
    endgenerate

    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] CNT_TURN = WIDTH'(MODULUS - 2);

    // MODULUS can equal 2**WIDTH, so the load range check needs one extra bit.
    localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             tc_q,  tc_d;
    logic             ovf_q, ovf_d;

    logic             at_max;
    logic             at_zero;
    logic             load_in_range;

    // ">=" keeps the limit test safe even if the count were ever out of range.
    assign at_max        = (cnt_q >= CNT_MAX);
    assign at_zero       = (cnt_q == CNT_ZERO);
    assign load_in_range = ({1'b0, i_data} < MOD_EXT);

    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        tc_d  = 1'b0;
        ovf_d = ovf_q;

        if (i_clr) begin
            cnt_d = CNT_ZERO;
            dir_d = 1'b0;
            ovf_d = 1'b0;
        end else if (i_load) begin
            cnt_d = load_in_range ? i_data : CNT_MAX;
        end else if (i_en) begin
            case (i_mode)
                MODE_UP: begin
                    dir_d = 1'b0;
                    if (at_max) begin
                        tc_d  = 1'b1;
                        ovf_d = 1'b1;
                        if (SATURATE == 0) begin
                            cnt_d = CNT_ZERO;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                MODE_DOWN: begin
                    dir_d = 1'b1;
                    if (at_zero) begin
                        tc_d  = 1'b1;
                        ovf_d = 1'b1;
                        if (SATURATE == 0) begin
                            cnt_d = CNT_MAX;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                MODE_BOUNCE: begin
                    // Reversal steps move one count away from the limit in the
                    // same edge, so the limit value is never repeated.
                    if (!dir_q && at_max) begin
                        cnt_d = CNT_TURN;
                        dir_d = 1'b1;
                        tc_d  = 1'b1;
                    end else if (dir_q && at_zero) begin
                        cnt_d = CNT_ONE;
                        dir_d = 1'b0;
                        tc_d  = 1'b1;
                    end else if (dir_q) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    // Hold mode: all state keeps its value, tc stays low.
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= CNT_ZERO;
            dir_q <= 1'b0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign o_cnt = cnt_q;
    assign o_dir = dir_q;
    assign o_tc  = tc_q;
    assign o_ovf = ovf_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_updown_counter
//
// Four counter instances share one set of control inputs:
//   u_wrap : WIDTH=4, MODULUS=10, SATURATE=0
//   u_sat  : WIDTH=4, MODULUS=10, SATURATE=1
//   u_bnc  : WIDTH=4, MODULUS=4
//   u_m2   : WIDTH=1, MODULUS=2
// Each scenario checks only the instance it is aimed at. Expected values are
// hand-computed vectors, except for the enable/hold run, which uses a small
// reference counter.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mod_updown_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic       load;
    logic [3:0] data;
    logic [1:0] mode;

    logic [3:0] w_cnt, s_cnt, b_cnt;
    logic [0:0] m_cnt;
    logic       w_dir, s_dir, b_dir, m_dir;
    logic       w_tc,  s_tc,  b_tc,  m_tc;
    logic       w_ovf, s_ovf, b_ovf, m_ovf;

    int checks;
    int failures;

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_wrap (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_load(load),
        .i_data(data), .i_mode(mode),
        .o_cnt(w_cnt), .o_dir(w_dir), .o_tc(w_tc), .o_ovf(w_ovf)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_sat (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_load(load),
        .i_data(data), .i_mode(mode),
        .o_cnt(s_cnt), .o_dir(s_dir), .o_tc(s_tc), .o_ovf(s_ovf)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(4), .SATURATE(0)) u_bnc (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_load(load),
        .i_data(data), .i_mode(mode),
        .o_cnt(b_cnt), .o_dir(b_dir), .o_tc(b_tc), .o_ovf(b_ovf)
    );

    mod_updown_counter #(.WIDTH(1), .MODULUS(2), .SATURATE(0)) u_m2 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_load(load),
        .i_data(data[0:0]), .i_mode(mode),
        .o_cnt(m_cnt), .o_dir(m_dir), .o_tc(m_tc), .o_ovf(m_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then sample 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounce, MODULUS=4, 10 steps from 0 with dir=0.
    int bnc_cnt[10] = '{1, 2, 3, 2, 1, 0, 1, 2, 3, 2};
    int bnc_tc [10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    int bnc_dir[10] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1};

    initial begin
        int ref_cnt;
        int ref_tc;

        checks   = 0;
        failures = 0;
        rst  = 1'b1;
        en   = 1'b0;
        clr  = 1'b0;
        load = 1'b0;
        data = 4'd0;
        mode = 2'b00;

        // Reset held across edges.
        step();
        step();
        check_val("rst_cnt", 32'(w_cnt), 0);
        check_val("rst_dir", 32'(w_dir), 0);
        check_val("rst_tc",  32'(w_tc),  0);
        check_val("rst_ovf", 32'(w_ovf), 0);
        rst = 1'b0;

        // Up mode wrap, MODULUS=10.
        en   = 1'b1;
        mode = 2'b00;
        for (int i = 1; i <= 12; i++) begin
            step();
            $display("up_wrap step=%0d cnt=%0d tc=%0d ovf=%0d", i, w_cnt, w_tc, w_ovf);
            check_val("up_cnt", 32'(w_cnt), 32'(i % 10));
            check_val("up_tc",  32'(w_tc),  (i == 10) ? 1 : 0);
            check_val("up_ovf", 32'(w_ovf), (i >= 10) ? 1 : 0);
        end

        // Clear, then down mode from 0 wraps to 9.
        en  = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        check_val("clr_cnt", 32'(w_cnt), 0);
        check_val("clr_ovf", 32'(w_ovf), 0);
        en   = 1'b1;
        mode = 2'b01;
        step();
        $display("down_wrap cnt=%0d tc=%0d dir=%0d", w_cnt, w_tc, w_dir);
        check_val("dn_cnt0", 32'(w_cnt), 9);
        check_val("dn_tc0",  32'(w_tc),  1);
        check_val("dn_ovf0", 32'(w_ovf), 1);
        check_val("dn_dir0", 32'(w_dir), 1);
        step();
        check_val("dn_cnt1", 32'(w_cnt), 8);
        check_val("dn_tc1",  32'(w_tc),  0);

        // Saturating up from 8.
        en   = 1'b0;
        clr  = 1'b1;
        step();
        clr  = 1'b0;
        load = 1'b1;
        data = 4'd8;
        step();
        load = 1'b0;
        check_val("sat_load", 32'(s_cnt), 8);
        en   = 1'b1;
        mode = 2'b00;
        for (int i = 1; i <= 4; i++) begin
            step();
            $display("sat_up step=%0d cnt=%0d tc=%0d", i, s_cnt, s_tc);
            check_val("sat_up_cnt", 32'(s_cnt), 9);
            check_val("sat_up_tc",  32'(s_tc),  (i >= 2) ? 1 : 0);
        end
        check_val("sat_up_ovf", 32'(s_ovf), 1);

        // Saturating down from 1.
        en   = 1'b0;
        load = 1'b1;
        data = 4'd1;
        step();
        load = 1'b0;
        en   = 1'b1;
        mode = 2'b01;
        step();
        $display("sat_dn step=1 cnt=%0d tc=%0d", s_cnt, s_tc);
        check_val("sat_dn_cnt0", 32'(s_cnt), 0);
        check_val("sat_dn_tc0",  32'(s_tc),  0);
        step();
        $display("sat_dn step=2 cnt=%0d tc=%0d", s_cnt, s_tc);
        check_val("sat_dn_cnt1", 32'(s_cnt), 0);
        check_val("sat_dn_tc1",  32'(s_tc),  1);

        // Bounce, MODULUS=4 and MODULUS=2.
        en  = 1'b0;
        clr = 1'b1;
        step();
        clr  = 1'b0;
        en   = 1'b1;
        mode = 2'b10;
        for (int i = 0; i < 10; i++) begin
            step();
            $display("bounce step=%0d cnt=%0d dir=%0d tc=%0d m2=%0d m2_tc=%0d",
                     i + 1, b_cnt, b_dir, b_tc, m_cnt, m_tc);
            check_val("bnc_cnt", 32'(b_cnt), 32'(bnc_cnt[i]));
            check_val("bnc_tc",  32'(b_tc),  32'(bnc_tc[i]));
            check_val("bnc_dir", 32'(b_dir), 32'(bnc_dir[i]));
            check_val("bnc_ovf", 32'(b_ovf), 0);
            check_val("m2_cnt",  32'(m_cnt), 32'((i + 1) % 2));
            check_val("m2_tc",   32'(m_tc),  (i >= 1) ? 1 : 0);
        end

        // Hold mode with enable high: everything frozen, tc low.
        mode = 2'b11;
        step();
        check_val("hold_cnt", 32'(b_cnt), 2);
        check_val("hold_dir", 32'(b_dir), 1);
        check_val("hold_tc",  32'(b_tc),  0);

        // Bounce resumes in the stored direction (down).
        mode = 2'b10;
        step();
        check_val("bnc_resume", 32'(b_cnt), 1);

        // Priority: clear beats load and enable.
        clr  = 1'b1;
        load = 1'b1;
        en   = 1'b1;
        mode = 2'b00;
        data = 4'd7;
        step();
        $display("prio clr+load+en cnt=%0d", w_cnt);
        check_val("prio_clr", 32'(w_cnt), 0);

        // Load beats enable, with clamping to MODULUS-1.
        clr  = 1'b0;
        data = 4'd13;
        step();
        $display("load 13 cnt=%0d", w_cnt);
        check_val("ld_clamp", 32'(w_cnt), 9);
        check_val("ld_tc",    32'(w_tc),  0);
        check_val("ld_ovf0",  32'(w_ovf), 0);

        // Overflow, then a load with enable low must leave ovf set.
        load = 1'b0;
        step();
        check_val("ld_wrap_tc", 32'(w_tc),  1);
        en   = 1'b0;
        load = 1'b1;
        data = 4'd5;
        step();
        load = 1'b0;
        $display("load 5 cnt=%0d ovf=%0d", w_cnt, w_ovf);
        check_val("ld_cnt5",  32'(w_cnt), 5);
        check_val("ld_ovf1",  32'(w_ovf), 1);
        check_val("ld_tc5",   32'(w_tc),  0);

        // Random enable and mode 11 against a reference counter.
        clr = 1'b1;
        step();
        clr     = 1'b0;
        ref_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            en   = 1'($urandom_range(0, 1));
            mode = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
            ref_tc = 0;
            if (en && mode == 2'b00) begin
                if (ref_cnt == 9) begin
                    ref_tc = 1;
                end
                ref_cnt = (ref_cnt + 1) % 10;
            end
            step();
            $display("en_hold step=%0d en=%0d mode=%0d cnt=%0d tc=%0d",
                     i, en, mode, w_cnt, w_tc);
            check_val("eh_cnt", 32'(w_cnt), 32'(ref_cnt));
            check_val("eh_tc",  32'(w_tc),  32'(ref_tc));
        end

        // Asynchronous reset mid-cycle with count 9, dir 1, tc 1 and ovf 1.
        en   = 1'b0;
        load = 1'b1;
        data = 4'd0;
        step();
        load = 1'b0;
        en   = 1'b1;
        mode = 2'b01;
        step();
        en = 1'b0;
        check_val("pre_rst_cnt", 32'(w_cnt), 9);
        #2;
        rst = 1'b1;
        #1;
        $display("async rst cnt=%0d dir=%0d tc=%0d ovf=%0d", w_cnt, w_dir, w_tc, w_ovf);
        check_val("arst_cnt", 32'(w_cnt), 0);
        check_val("arst_dir", 32'(w_dir), 0);
        check_val("arst_tc",  32'(w_tc),  0);
        check_val("arst_ovf", 32'(w_ovf), 0);
        en   = 1'b1;
        mode = 2'b00;
        step();
        step();
        check_val("arst_hold", 32'(w_cnt), 0);
        rst = 1'b0;
        step();
        check_val("arst_resume", 32'(w_cnt), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
